// File: rtl/match_count_accum.sv
// match_count_accum: gathers per-index match counts and sticky aligned-match
// flags over a window of input beats. When the window closes, the result is
// presented to the downstream max tree with a valid/ready handshake.
module match_count_accum #(
    parameter int NUM_IDX = 16,
    parameter int WIDTH   = 2,
    parameter int WINDOW  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_IDX-1:0]       i_match,
    input  logic [NUM_IDX-1:0]       i_align,
    input  logic                     i_last,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_IDX*WIDTH-1:0] o_count,
    output logic [NUM_IDX-1:0]       o_align,
    output logic [7:0]               o_beats
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    // The window closes on the beat that arrives while the counter shows
    // WINDOW-1 beats. With WINDOW=256 a full window reads back as 0 beats
    // because the counter is 8 bits wide.
    localparam logic [7:0]       LAST_BEAT = 8'(WINDOW - 1);

    state_t                          state_q, state_d;
    logic [NUM_IDX-1:0][WIDTH-1:0]   count_q, count_d;
    logic [NUM_IDX-1:0]              align_q, align_d;
    logic [7:0]                      beats_q, beats_d;

    assign o_ready = (state_q == ACCUM);
    assign o_valid = (state_q == HOLD);
    assign o_count = count_q;
    assign o_align = align_q;
    assign o_beats = beats_q;

    // Next-state: accumulate accepted beats, close the window, clear on consume
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        align_d = align_q;
        beats_d = beats_q;
        case (state_q)
            ACCUM: begin
                if (i_valid) begin
                    for (int k = 0; k < NUM_IDX; k++) begin
                        if (i_match[k]) begin
                            if (count_q[k] != CNT_MAX)
                                count_d[k] = count_q[k] + CNT_ONE;
                            if (i_align[k])
                                align_d[k] = 1'b1;
                        end
                    end
                    beats_d = beats_q + 8'd1;
                    if (i_last || (beats_q == LAST_BEAT))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    count_d = '0;
                    align_d = '0;
                    beats_d = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and window registers. Reset discards any partial or held window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            count_q <= '0;
            align_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            align_q <= align_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_match_count_accum.sv
// Testbench for match_count_accum: directed scenarios followed by a random
// stream, all checked against a window-level reference model.
module tb_match_count_accum;

    localparam int NUM_IDX = 16;
    localparam int WIDTH   = 2;
    localparam int WINDOW  = 8;
    localparam int CMAX    = (1 << WIDTH) - 1;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_valid = 1'b0;
    logic                     o_ready;
    logic [NUM_IDX-1:0]       i_match = '0;
    logic [NUM_IDX-1:0]       i_align = '0;
    logic                     i_last = 1'b0;
    logic                     o_valid;
    logic                     i_ready = 1'b0;
    logic [NUM_IDX*WIDTH-1:0] o_count;
    logic [NUM_IDX-1:0]       o_align;
    logic [7:0]               o_beats;

    match_count_accum #(.NUM_IDX(NUM_IDX), .WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_match(i_match), .i_align(i_align), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_align(o_align), .o_beats(o_beats)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_win  = 0;

    // Reference model: one window's worth of plain integer counts
    int                 m_cnt[NUM_IDX];
    bit [NUM_IDX-1:0]   m_al;
    int                 m_beats;
    bit                 m_hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_IDX; k++) m_cnt[k] = 0;
        m_al    = '0;
        m_beats = 0;
        m_hold  = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the model
    task automatic model_edge(input bit v, input bit [NUM_IDX-1:0] m,
                              input bit [NUM_IDX-1:0] a, input bit l, input bit r);
        if (!m_hold) begin
            if (v) begin
                for (int k = 0; k < NUM_IDX; k++) begin
                    if (m[k]) begin
                        if (m_cnt[k] < CMAX) m_cnt[k]++;
                        if (a[k]) m_al[k] = 1'b1;
                    end
                end
                m_beats++;
                if (l || m_beats == WINDOW) m_hold = 1'b1;
            end
        end else if (r) begin
            n_win++;
            model_clear();
        end
    endtask

    function automatic logic [NUM_IDX*WIDTH-1:0] exp_count();
        logic [NUM_IDX*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_IDX; k++) v[k*WIDTH +: WIDTH] = WIDTH'(m_cnt[k]);
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_hold));
        chk({tag, ".ready"}, 64'(o_ready), 64'(!m_hold));
        chk({tag, ".beats"}, 64'(o_beats), 64'(m_beats & 8'hff));
        chk({tag, ".count"}, 64'(o_count), 64'(exp_count()));
        chk({tag, ".align"}, 64'(o_align), 64'(m_al));
    endtask

    // Drive inputs, take one rising edge, then check away from the edge
    task automatic step(input bit v, input bit [NUM_IDX-1:0] m, input bit [NUM_IDX-1:0] a,
                        input bit l, input bit r, input string tag);
        i_valid = v; i_match = m; i_align = a; i_last = l; i_ready = r;
        @(posedge i_clk);
        model_edge(v, m, a, l, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_clear();

        // Reset state
        #12;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Three beats, early close on i_last
        step(1, 16'h0001, '0, 0, 0, "w3_b1");
        step(1, 16'h0003, '0, 0, 0, "w3_b2");
        step(1, 16'h0001, '0, 1, 0, "w3_b3");
        chk("w3_count_const", 64'(o_count), 64'h7);
        chk("w3_beats_const", 64'(o_beats), 64'd3);
        step(0, '0, '0, 0, 1, "w3_consume");

        // Saturation and close on the WINDOW-th beat without i_last
        for (int b = 0; b < WINDOW; b++) step(1, 16'h0020, '0, 0, 0, "sat");
        chk("sat_valid_const", 64'(o_valid), 64'd1);
        chk("sat_count_const", 64'(o_count), 64'h0C00);
        chk("sat_beats_const", 64'(o_beats), 64'd8);
        step(0, '0, '0, 0, 1, "sat_consume");

        // Sticky align; align without match ignored
        step(1, 16'h0004, 16'h0080, 0, 0, "al_b1");
        step(1, 16'h0004, 16'h0004, 0, 0, "al_b2");
        step(1, 16'h0004, 16'h0080, 1, 0, "al_b3");
        chk("al_align_const", 64'(o_align), 64'h0004);
        step(0, '0, '0, 0, 1, "al_consume");

        // HOLD backpressure with inputs toggling
        step(1, 16'h8001, '0, 1, 0, "bp_close");
        for (int c = 0; c < 5; c++)
            step(1, 16'($urandom), 16'($urandom), 1'($urandom), 0, "bp_hold");
        step(1, 16'hffff, '0, 0, 1, "bp_consume");
        chk("bp_count_zero", 64'(o_count), 64'h0);

        // Asynchronous reset mid-window
        for (int b = 0; b < 4; b++) step(1, 16'h00f0, 16'h0010, 0, 0, "rst_pre");
        #2;
        i_rst_n = 1'b0;
        model_clear();
        #1;
        check_all("rst_async");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1, 16'h0100, '0, 0, 0, "rst_w_b1");
        step(1, 16'h0300, '0, 1, 0, "rst_w_b2");
        chk("rst_w_beats_const", 64'(o_beats), 64'd2);
        step(0, '0, '0, 0, 1, "rst_w_consume");

        // Random stream with random backpressure
        for (int s = 0; s < 400; s++)
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                 ($urandom % 6) == 0, 1'($urandom), "rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
